multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 `clock  in  1  rising-edge clock for all state.`
REQ-003 `rst  in  1  synchronous, active-high reset.`
REQ-004 `opcode  in  6  Inst[31:26] from the instruction register.`
REQ-005 `funct  in  6  Inst[5:0] from the instruction register.`
REQ-006 `zero  in  1  ALU zero flag, same cycle.`
REQ-007 Outputs, all 1-bit unless noted:
- pc_en: PC load.
- i_or_d: 0=PC, 1=ALUOut memory address.
- mem_read, mem_write, ir_write, reg_write.
- reg_dst[2]: 00=rt, 01=rd, 10=$31.
- mem_to_reg[2]: 00=ALUOut, 01=MDR, 10=PC.
- alu_src_a: 0=PC, 1=A.
- alu_src_b[2]: 00=B, 01=const 4, 10=signext, 11=signext<<2.
- alu_opc[3]: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- pc_src[2]: 00=ALU result, 01=ALUOut, 10={PC[31:28],Inst[25:0],00}, 11=A.

Function
REQ-008 The controller SHALL be a Moore FSM with 14 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, BRANCH, JUMP, IMMEX, IMMWB, JAL, JR.
- The only Mealy term SHALL be pc_en in BRANCH.
REQ-009 Unasserted outputs SHALL be 0 in every state.
- Unlisted muxes SHALL be 00.
- alu_opc SHALL default to 010.
REQ-010 FETCH outputs:
- mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, alu_opc=010, pc_src=00, pc_en=1.
- Next state: DECODE.
REQ-011 DECODE outputs: alu_src_a=0, alu_src_b=11, alu_opc=010 (branch target into ALUOut).
REQ-012 DECODE transitions:
- lw 100011 and sw 101011 go to MEMADR.
- R-type 000000 with funct 001000 goes to JR; other R-type goes to RTEX.
- beq 000100 and bne 000101 go to BRANCH.
- j 000010 goes to JUMP.
- jal 000011 goes to JAL.
- addi 001000 and slti 001010 go to IMMEX.
- Any other opcode goes to FETCH, executing as a 2-cycle nop.
REQ-013 MEMADR outputs: alu_src_a=1, alu_src_b=10, add. Next state: MEMRD for lw, MEMWR for sw.
REQ-014 MEMRD: mem_read=1, i_or_d=1; next MEMWB.
REQ-015 MEMWB: reg_dst=00, mem_to_reg=01, reg_write=1; next FETCH.
REQ-016 MEMWR: mem_write=1, i_or_d=1; next FETCH.
REQ-017 RTEX: alu_src_a=1, alu_src_b=00, alu_opc decoded from funct; next RTWB.
- 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Any other funct SHALL give add.
REQ-018 RTWB: reg_dst=01, mem_to_reg=00, reg_write=1; next FETCH.
REQ-019 IMMEX: alu_src_a=1, alu_src_b=10, alu_opc add (addi) or slt (slti); next IMMWB.
REQ-020 IMMWB: reg_dst=00, mem_to_reg=00, reg_write=1; next FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_opc=110, pc_src=01; next FETCH.
- pc_en = zero for beq, ~zero for bne.
REQ-022 JUMP: pc_src=10, pc_en=1; next FETCH.
REQ-023 JAL: reg_dst=10, mem_to_reg=10, reg_write=1, pc_src=10, pc_en=1; next FETCH.
- $31 receives the PC already incremented in FETCH.
REQ-024 JR: pc_src=11, pc_en=1; next FETCH.
REQ-025 Instruction latency in cycles SHALL be: lw 5; sw, R-type, addi, slti 4; beq, bne, j, jal, jr 3.
REQ-026 mem_read and mem_write SHALL never both be 1 in the same cycle.
- reg_write and mem_write SHALL never both be 1 in the same cycle.

Reset
REQ-027 On a rising clock edge with rst=1, the state SHALL become FETCH, regardless of current state, including mid-instruction.
REQ-028 While rst=1, pc_en, ir_write, reg_write and mem_write SHALL be forced to 0.
REQ-029 After rst is released, the first cycle SHALL present the FETCH outputs.

Structure
REQ-030 A shared package SHALL hold the opcode and funct constants, the alu_opc codes, the mux-select codes and the state encoding.
REQ-031 Funct-to-alu_opc decoding SHALL be a sub-module alu_control, instantiated once.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Reset, then lw: states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. reg_write=1 only in cycle 5, with mem_to_reg=01.
- beq with zero=1: pc_en=1 in cycle 3. Same with zero=0: pc_en=0. bne with zero=0: pc_en=1.
- R-type sub (funct 100010): alu_opc=110 in RTEX. RTWB has reg_dst=01 and reg_write=1. Total 4 cycles.
- jal: cycle 3 has reg_dst=10, mem_to_reg=10, pc_src=10, pc_en=1. jr (funct 001000): cycle 3 has pc_src=11, pc_en=1.
- Unknown opcode 111111: DECODE goes straight to FETCH, with no reg_write or mem_write.
- rst=1 asserted in MEMWR: mem_write=0 that cycle, next state FETCH.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, functs,
// ALU operation codes, datapath mux selects and the FSM state encoding.
// Pure declarations; no logic, no latency, no flow control.
package multi_cycle_controller_pkg;

    // Instruction opcodes, Inst[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes, Inst[5:0]
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_opc_t;

    // Register-file write address select
    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    // Register-file write data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // ALU operand selects
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_A       = 1'b1;
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_A      = 2'b11;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        RTWB   = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IMMEX  = 4'd10,
        IMMWB  = 4'd11,
        JAL    = 4'd12,
        JR     = 4'd13
    } state_t;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in, control strobes out.
// Wires only; zero latency.
// No backpressure: the datapath consumes the controls every cycle.
//   master : controller side (reads opcode/funct/zero, drives controls and state)
//   slave  : datapath side (drives opcode/funct/zero, reads controls)
interface multi_cycle_controller_if;
    import multi_cycle_controller_pkg::*;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_opc_t   alu_opc;
    logic [1:0] pc_src;
    state_t     state;      // current FSM state, for observation

    modport master (
        input  opcode, funct, zero,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_opc, pc_src, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_opc, pc_src, state
    );

endinterface

// File: rtl/alu_control.sv
// Maps an R-type funct field to the ALU operation code.
// Combinational, zero latency.
// No backpressure.
//   funct   : Inst[5:0]
//   alu_opc : ALU operation; unrecognised functs fall back to add
module alu_control
    import multi_cycle_controller_pkg::*;
(
    input  logic [5:0] funct,
    output alu_opc_t   alu_opc
);

    always_comb begin
        alu_opc = ALU_ADD;
        case (funct)
            FN_ADD:  alu_opc = ALU_ADD;
            FN_SUB:  alu_opc = ALU_SUB;
            FN_AND:  alu_opc = ALU_AND;
            FN_OR:   alu_opc = ALU_OR;
            FN_SLT:  alu_opc = ALU_SLT;
            default: alu_opc = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM sequencing the multi-cycle MIPS datapath (14 states).
// Latency: lw 5 cycles; sw/R-type/addi/slti 4; beq/bne/j/jal/jr 3; unknown opcodes 2.
// No backpressure; one state step per clock.
//   clock : rising-edge clock
//   rst   : synchronous active-high reset; forces FETCH and masks the state-changing strobes
//   ctrl  : opcode/funct/zero in, datapath controls and current state out
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
(
    input  logic                      clock,
    input  logic                      rst,
    multi_cycle_controller_if.master  ctrl
);

    state_t     state_q;
    state_t     state_d;
    alu_opc_t   funct_opc;

    logic       pc_en_c;
    logic       i_or_d_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic [1:0] reg_dst_c;
    logic [1:0] mem_to_reg_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    alu_opc_t   alu_opc_c;
    logic [1:0] pc_src_c;

    alu_control u_alu_control (
        .funct   (ctrl.funct),
        .alu_opc (funct_opc)
    );

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. opcode/funct come from the instruction register,
    // which holds the current instruction from DECODE onward.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (ctrl.opcode)
                    OP_LW, OP_SW:     state_d = MEMADR;
                    OP_RTYPE:         state_d = (ctrl.funct == FN_JR) ? JR : RTEX;
                    OP_BEQ, OP_BNE:   state_d = BRANCH;
                    OP_J:             state_d = JUMP;
                    OP_JAL:           state_d = JAL;
                    OP_ADDI, OP_SLTI: state_d = IMMEX;
                    default:          state_d = FETCH;   // unknown opcode: 2-cycle nop
                endcase
            end
            MEMADR: state_d = (ctrl.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MEMWB;
            RTEX:   state_d = RTWB;
            IMMEX:  state_d = IMMWB;
            default: state_d = FETCH;  // MEMWB, MEMWR, RTWB, BRANCH, JUMP, IMMWB, JAL, JR
        endcase
    end

    // Output logic: Moore except pc_en in BRANCH, which follows the zero flag.
    always_comb begin
        pc_en_c      = 1'b0;
        i_or_d_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = REG_DST_RT;
        mem_to_reg_c = M2R_ALUOUT;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_B;
        alu_opc_c    = ALU_ADD;
        pc_src_c     = PCSRC_ALU;
        case (state_q)
            FETCH: begin
                mem_read_c  = 1'b1;
                ir_write_c  = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                pc_en_c     = 1'b1;
            end
            DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b_c = SRCB_IMM_SH2;
            end
            MEMADR: begin
                alu_src_a_c = SRCA_A;
                alu_src_b_c = SRCB_IMM;
            end
            MEMRD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
            end
            MEMWB: begin
                mem_to_reg_c = M2R_MDR;
                reg_write_c  = 1'b1;
            end
            MEMWR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
            end
            RTEX: begin
                alu_src_a_c = SRCA_A;
                alu_opc_c   = funct_opc;
            end
            RTWB: begin
                reg_dst_c   = REG_DST_RD;
                reg_write_c = 1'b1;
            end
            BRANCH: begin
                alu_src_a_c = SRCA_A;
                alu_opc_c   = ALU_SUB;
                pc_src_c    = PCSRC_ALUOUT;
                pc_en_c     = (ctrl.opcode == OP_BNE) ? ~ctrl.zero : ctrl.zero;
            end
            JUMP: begin
                pc_src_c = PCSRC_JUMP;
                pc_en_c  = 1'b1;
            end
            IMMEX: begin
                alu_src_a_c = SRCA_A;
                alu_src_b_c = SRCB_IMM;
                alu_opc_c   = (ctrl.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            IMMWB: begin
                reg_write_c = 1'b1;
            end
            JAL: begin
                // PC was already incremented in FETCH, so it is the link value.
                reg_dst_c    = REG_DST_RA;
                mem_to_reg_c = M2R_PC;
                reg_write_c  = 1'b1;
                pc_src_c     = PCSRC_JUMP;
                pc_en_c      = 1'b1;
            end
            JR: begin
                pc_src_c = PCSRC_A;
                pc_en_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural-state strobes are masked during reset so nothing is
    // committed from whatever state the FSM happens to be in.
    assign ctrl.pc_en      = pc_en_c     & ~rst;
    assign ctrl.ir_write   = ir_write_c  & ~rst;
    assign ctrl.reg_write  = reg_write_c & ~rst;
    assign ctrl.mem_write  = mem_write_c & ~rst;
    assign ctrl.i_or_d     = i_or_d_c;
    assign ctrl.mem_read   = mem_read_c;
    assign ctrl.reg_dst    = reg_dst_c;
    assign ctrl.mem_to_reg = mem_to_reg_c;
    assign ctrl.alu_src_a  = alu_src_a_c;
    assign ctrl.alu_src_b  = alu_src_b_c;
    assign ctrl.alu_opc    = alu_opc_c;
    assign ctrl.pc_src     = pc_src_c;
    assign ctrl.state      = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: per-cycle vectors built
// from instruction sequences, applied through a scoreboard queue.
module tb_multi_cycle_controller;
    import multi_cycle_controller_pkg::*;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    multi_cycle_controller_if ifc ();

    multi_cycle_controller dut (
        .clock (clock),
        .rst   (rst),
        .ctrl  (ifc)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_opc;
        logic [1:0] pc_src;
    } ctl_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        state_t     st;
        ctl_t       c;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Expected control words, one per state, written straight from the state table.
    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.alu_opc = 3'b010;
        return c;
    endfunction

    function automatic ctl_t e_fetch();
        ctl_t c = idle();
        c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.pc_en = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_decode();
        ctl_t c = idle();
        c.alu_src_b = 2'b11;
        return c;
    endfunction

    function automatic ctl_t e_memadr();
        ctl_t c = idle();
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        return c;
    endfunction

    function automatic ctl_t e_memrd();
        ctl_t c = idle();
        c.mem_read = 1'b1; c.i_or_d = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_memwb();
        ctl_t c = idle();
        c.mem_to_reg = 2'b01; c.reg_write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_memwr();
        ctl_t c = idle();
        c.mem_write = 1'b1; c.i_or_d = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_ex(input logic [1:0] srcb, input logic [2:0] opc);
        ctl_t c = idle();
        c.alu_src_a = 1'b1; c.alu_src_b = srcb; c.alu_opc = opc;
        return c;
    endfunction

    function automatic ctl_t e_wb(input logic [1:0] dst);
        ctl_t c = idle();
        c.reg_dst = dst; c.reg_write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_branch(input logic pcen);
        ctl_t c = idle();
        c.alu_src_a = 1'b1; c.alu_opc = 3'b110; c.pc_src = 2'b01; c.pc_en = pcen;
        return c;
    endfunction

    function automatic ctl_t e_jump(input logic [1:0] src);
        ctl_t c = idle();
        c.pc_src = src; c.pc_en = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_jal();
        ctl_t c = idle();
        c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; c.reg_write = 1'b1;
        c.pc_src = 2'b10; c.pc_en = 1'b1;
        return c;
    endfunction

    // Strobes that reset must hold low.
    function automatic ctl_t masked(input ctl_t c_in);
        ctl_t c = c_in;
        c.pc_en = 1'b0; c.ir_write = 1'b0; c.reg_write = 1'b0; c.mem_write = 1'b0;
        return c;
    endfunction

    task automatic push(input string nm, input logic r, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input state_t st, input ctl_t c);
        vec_t v;
        v.name = nm; v.rst = r; v.op = op; v.fn = fn; v.z = z; v.st = st; v.c = c;
        vecs.push_back(v);
    endtask

    // Appends every cycle of one instruction, starting at FETCH.
    task automatic instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic [2:0] eopc, input logic epc);
        push({nm, ".fetch"},  1'b0, op, fn, z, FETCH,  e_fetch());
        push({nm, ".decode"}, 1'b0, op, fn, z, DECODE, e_decode());
        case (op)
            6'b100011: begin
                push({nm, ".memadr"}, 1'b0, op, fn, z, MEMADR, e_memadr());
                push({nm, ".memrd"},  1'b0, op, fn, z, MEMRD,  e_memrd());
                push({nm, ".memwb"},  1'b0, op, fn, z, MEMWB,  e_memwb());
            end
            6'b101011: begin
                push({nm, ".memadr"}, 1'b0, op, fn, z, MEMADR, e_memadr());
                push({nm, ".memwr"},  1'b0, op, fn, z, MEMWR,  e_memwr());
            end
            6'b000000: begin
                if (fn == 6'b001000) begin
                    push({nm, ".jr"}, 1'b0, op, fn, z, JR, e_jump(2'b11));
                end else begin
                    push({nm, ".rtex"}, 1'b0, op, fn, z, RTEX, e_ex(2'b00, eopc));
                    push({nm, ".rtwb"}, 1'b0, op, fn, z, RTWB, e_wb(2'b01));
                end
            end
            6'b000100, 6'b000101:
                push({nm, ".branch"}, 1'b0, op, fn, z, BRANCH, e_branch(epc));
            6'b000010:
                push({nm, ".jump"}, 1'b0, op, fn, z, JUMP, e_jump(2'b10));
            6'b000011:
                push({nm, ".jal"}, 1'b0, op, fn, z, JAL, e_jal());
            6'b001000, 6'b001010: begin
                push({nm, ".immex"}, 1'b0, op, fn, z, IMMEX, e_ex(2'b10, eopc));
                push({nm, ".immwb"}, 1'b0, op, fn, z, IMMWB, e_wb(2'b00));
            end
            default: ;  // unknown opcode: next cycle is the following FETCH
        endcase
    endtask

    function automatic ctl_t actual();
        ctl_t c;
        c.pc_en      = ifc.pc_en;
        c.i_or_d     = ifc.i_or_d;
        c.mem_read   = ifc.mem_read;
        c.mem_write  = ifc.mem_write;
        c.ir_write   = ifc.ir_write;
        c.reg_write  = ifc.reg_write;
        c.reg_dst    = ifc.reg_dst;
        c.mem_to_reg = ifc.mem_to_reg;
        c.alu_src_a  = ifc.alu_src_a;
        c.alu_src_b  = ifc.alu_src_b;
        c.alu_opc    = ifc.alu_opc;
        c.pc_src     = ifc.pc_src;
        return c;
    endfunction

    task automatic check(input vec_t v);
        ctl_t       a;
        logic [1:0] excl;
        a = actual();
        n_tests++;
        if (ifc.state !== v.st) begin
            n_fail++;
            $display("FAIL %s state: got %0d want %0d", v.name, ifc.state, v.st);
        end
        n_tests++;
        if (a !== v.c) begin
            n_fail++;
            $display("FAIL %s controls: got %h want %h", v.name, a, v.c);
        end
        excl = {ifc.mem_read & ifc.mem_write, ifc.reg_write & ifc.mem_write};
        n_tests++;
        if (excl !== 2'b00) begin
            n_fail++;
            $display("FAIL %s exclusive strobes: got %b want 00", v.name, excl);
        end
    endtask

    initial begin
        vec_t v;
        vec_t e;

        ifc.opcode = 6'd0;
        ifc.funct  = 6'd0;
        ifc.zero   = 1'b0;

        // Reset held, then released: FETCH with strobes masked, then full FETCH.
        push("reset", 1'b1, 6'b000000, 6'b000000, 1'b0, FETCH, masked(e_fetch()));
        instr("lw",      6'b100011, 6'b000000, 1'b0, 3'b010, 1'b0);
        instr("sw",      6'b101011, 6'b000000, 1'b0, 3'b010, 1'b0);
        instr("add",     6'b000000, 6'b100000, 1'b0, 3'b010, 1'b0);
        instr("sub",     6'b000000, 6'b100010, 1'b0, 3'b110, 1'b0);
        instr("and",     6'b000000, 6'b100100, 1'b1, 3'b000, 1'b0);
        instr("or",      6'b000000, 6'b100101, 1'b0, 3'b001, 1'b0);
        instr("slt",     6'b000000, 6'b101010, 1'b0, 3'b111, 1'b0);
        instr("rt_unk",  6'b000000, 6'b000111, 1'b0, 3'b010, 1'b0);
        instr("addi",    6'b001000, 6'b101010, 1'b0, 3'b010, 1'b0);
        instr("slti",    6'b001010, 6'b100000, 1'b0, 3'b111, 1'b0);
        instr("beq_z1",  6'b000100, 6'b000000, 1'b1, 3'b010, 1'b1);
        instr("beq_z0",  6'b000100, 6'b000000, 1'b0, 3'b010, 1'b0);
        instr("bne_z0",  6'b000101, 6'b000000, 1'b0, 3'b010, 1'b1);
        instr("bne_z1",  6'b000101, 6'b000000, 1'b1, 3'b010, 1'b0);
        instr("j",       6'b000010, 6'b000000, 1'b0, 3'b010, 1'b0);
        instr("jal",     6'b000011, 6'b000000, 1'b0, 3'b010, 1'b0);
        instr("jr",      6'b000000, 6'b001000, 1'b0, 3'b010, 1'b0);
        instr("unk3f",   6'b111111, 6'b000000, 1'b0, 3'b010, 1'b0);
        instr("unk0f",   6'b001111, 6'b100010, 1'b0, 3'b010, 1'b0);

        // Reset during MEMWR: write suppressed that cycle, FETCH next.
        push("rst_sw.fetch",  1'b0, 6'b101011, 6'b0, 1'b0, FETCH,  e_fetch());
        push("rst_sw.decode", 1'b0, 6'b101011, 6'b0, 1'b0, DECODE, e_decode());
        push("rst_sw.memadr", 1'b0, 6'b101011, 6'b0, 1'b0, MEMADR, e_memadr());
        push("rst_sw.memwr",  1'b1, 6'b101011, 6'b0, 1'b0, MEMWR,  masked(e_memwr()));
        instr("after_rst_sw", 6'b000000, 6'b100101, 1'b0, 3'b001, 1'b0);

        // Reset held for two cycles starting in RTEX.
        push("rst_rt.fetch",  1'b0, 6'b000000, 6'b100010, 1'b0, FETCH,  e_fetch());
        push("rst_rt.decode", 1'b0, 6'b000000, 6'b100010, 1'b0, DECODE, e_decode());
        push("rst_rt.rtex",   1'b1, 6'b000000, 6'b100010, 1'b0, RTEX,   e_ex(2'b00, 3'b110));
        push("rst_rt.hold",   1'b1, 6'b000000, 6'b100010, 1'b0, FETCH,  masked(e_fetch()));
        instr("after_rst_rt", 6'b100011, 6'b000000, 1'b0, 3'b010, 1'b0);

        // Reset during JAL: link write and PC load suppressed.
        push("rst_jal.fetch",  1'b0, 6'b000011, 6'b0, 1'b0, FETCH,  e_fetch());
        push("rst_jal.decode", 1'b0, 6'b000011, 6'b0, 1'b0, DECODE, e_decode());
        push("rst_jal.jal",    1'b1, 6'b000011, 6'b0, 1'b0, JAL,    masked(e_jal()));
        instr("after_rst_jal", 6'b000101, 6'b000000, 1'b1, 3'b010, 1'b0);

        // Let the initial reset take effect on the first rising edge.
        @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clock);
            rst        = v.rst;
            ifc.opcode = v.op;
            ifc.funct  = v.fn;
            ifc.zero   = v.z;
            sb.push_back(v);
            #1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard underflow at vector %0d", i);
            end else begin
                e = sb.pop_front();
                check(e);
            end
        end

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
